// File: rtl/pipe_pkg.sv
// Shared constants, handshake type and sizing helper for the pipeline stage buffer.
package pipe_pkg;

    localparam logic [31:0] NOP_INS = 32'h13;

    typedef struct packed {
        logic valid;
        logic ready;
    } pipe_hs_t;

    function automatic int LEVEL_W(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_buf_ram.sv
// DEPTH x WIDTH register array: one write port, one asynchronous read port, cleared on reset.
module pipe_buf_ram
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 97,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: DEPTH=1 register slice or DEPTH>=2 circular FIFO with bubble tagging.
// Optional perf counters (o_perf_stall, o_perf_bubble) are built when PIPE_BUF_PERF_EN is defined.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 96,
    parameter int                DEPTH      = 2,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_INS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_stall,
    input  logic                        i_flush,
    input  logic                        i_bubble,
    input  logic                        i_up_valid,
    output logic                        o_up_ready,
    input  logic [DATA_W-1:0]           i_up_data,
    output logic                        o_dn_valid,
    input  logic                        i_dn_ready,
    output logic [DATA_W-1:0]           o_dn_data,
    output logic                        o_dn_bubble,
    output logic [LEVEL_W(DEPTH)-1:0]   o_level
`ifdef PIPE_BUF_PERF_EN
    ,
    output logic [31:0]                 o_perf_stall,
    output logic [31:0]                 o_perf_bubble
`endif
);

    localparam int LVL_W = LEVEL_W(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (!(DEPTH == 1 || DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
            $error("pipe_stage_buf: DEPTH must be 1, 2, 4 or 8");
        end
    endgenerate

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [LVL_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    pipe_hs_t          up_hs;
    pipe_hs_t          dn_hs;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   wr_entry;
    logic [DATA_W:0]   rd_entry;

    assign o_dn_valid = (count != '0);

    // DEPTH=1 lets a pop free the slot in the same cycle; deeper buffers
    // decouple upstream ready from downstream ready.
    generate
        if (DEPTH == 1) begin : g_ready_slice
            assign o_up_ready = ~i_stall & (~o_dn_valid | i_dn_ready);
        end else begin : g_ready_fifo
            assign o_up_ready = ~i_stall & (count != LVL_W'(DEPTH));
        end
    endgenerate

    assign up_hs = '{valid: i_up_valid, ready: o_up_ready};
    assign dn_hs = '{valid: o_dn_valid, ready: i_dn_ready & ~i_stall};
    assign push  = up_hs.valid & up_hs.ready;
    assign pop   = dn_hs.valid & dn_hs.ready;

    assign wr_entry = {i_bubble, i_bubble ? BUBBLE_VAL : i_up_data};

    pipe_buf_ram #(
        .WIDTH  (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (push & ~i_flush),
        .i_waddr (wr_ptr),
        .i_wdata (wr_entry),
        .i_raddr (rd_ptr),
        .o_rdata (rd_entry)
    );

    assign o_dn_bubble = rd_entry[DATA_W];
    assign o_dn_data   = rd_entry[DATA_W-1:0];
    assign o_level     = count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + LVL_W'(1);
            end else if (pop && !push) begin
                count <= count - LVL_W'(1);
            end
        end
    end

`ifdef PIPE_BUF_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Counters survive flush; only reset clears them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_perf_stall  <= '0;
            o_perf_bubble <= '0;
        end else begin
            if (o_dn_valid && !i_dn_ready) begin
                o_perf_stall <= sat_inc(o_perf_stall);
            end
            if (push && i_bubble) begin
                o_perf_bubble <= sat_inc(o_perf_bubble);
            end
        end
    end
`endif

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline stage for inter-stage boundaries (IF/ID, ID/EX, ...), carrying a generic payload with valid/ready handshake, stall, flush and bubble insertion. DEPTH=1 gives a single pipeline register with a combinational ready path. DEPTH>=2 gives a small circular FIFO whose upstream ready does not depend on downstream ready, which breaks the timing path. Bubbles are tagged per entry so downstream stages and the difftest harness can identify inserted NOPs.

Parameters:
DATA_W, 96, payload width in bits (e.g. ins + pc + diffpc).
DEPTH, 2, entries; legal values are 1, 2, 4 and 8. Any other value is a compile-time error.
BUBBLE_VAL, {DATA_W{1'b0}} with the low 32 bits = 32'h13, payload substituted for bubbles (ADDI x0,x0,0; diffpc field 0).

Ports:
i_clk, in, 1, clock, rising edge.
i_rst_n, in, 1, reset; asynchronous, active-low.
i_stall, in, 1, freeze: no push, no pop.
i_flush, in, 1, discard all held entries.
i_bubble, in, 1, replace the pushed payload with BUBBLE_VAL and tag the entry as a bubble.
i_up_valid, in, 1, upstream payload valid.
o_up_ready, out, 1, stage can accept an entry.
i_up_data, in, DATA_W, upstream payload.
o_dn_valid, out, 1, head entry valid.
i_dn_ready, in, 1, downstream accepts the head entry.
o_dn_data, out, DATA_W, head payload.
o_dn_bubble, out, 1, head entry is a bubble.
o_level, out, $clog2(DEPTH+1), occupancy count.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - count, read pointer and write pointer = 0.
  - All storage and bubble tags = 0.
  - o_dn_valid = 0, o_dn_data = 0, o_dn_bubble = 0, o_level = 0.
  - o_up_ready follows its equation below.
- Handshake definitions:
  - push = i_up_valid & o_up_ready.
  - pop = o_dn_valid & i_dn_ready & ~i_stall.
- o_up_ready:
  - DEPTH=1: ~i_stall & (~o_dn_valid | i_dn_ready).
  - DEPTH>=2: ~i_stall & (count != DEPTH), with no combinational dependence on i_dn_ready.
- o_dn_valid = (count != 0). o_dn_data and o_dn_bubble come from the head entry.
- Latency: exactly 1 cycle from push to o_dn_valid. There is no fall-through.
- Stored payload on push = i_bubble ? BUBBLE_VAL : i_up_data. Stored tag = i_bubble.
- Pointers wrap modulo DEPTH. count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Full:
  - DEPTH>=2: no push even if a pop occurs in the same cycle.
  - DEPTH=1: simultaneous pop and push replaces the entry, sustaining 1 entry per cycle.
- Empty: pop cannot occur; o_dn_data holds the last head value and is don't-care for checking.
- i_stall: suppresses push and pop. Contents and outputs are held; o_dn_valid may remain 1.
- i_flush (synchronous, highest priority):
  - The next cycle has count = 0 and pointers = 0.
  - Any push or pop in the flush cycle is discarded or ignored, and o_dn_valid = 0 the next cycle.
  - Flush overrides stall.
- Reset asserted mid-transfer: all entries are lost immediately, with no partial update.

Optional Feature:
PIPE_BUF_PERF_EN
- Defined:
  - Adds outputs o_perf_stall [31:0] and o_perf_bubble [31:0], both saturating at 32'hFFFF_FFFF.
  - o_perf_stall counts cycles with o_dn_valid & ~i_dn_ready.
  - o_perf_bubble counts pushes with i_bubble = 1.
  - Both counters reset to 0 on reset; flush does not clear them.
- Undefined: the ports and counters are absent and the datapath is identical.

Decomposition:
- Package pipe_pkg holds:
  - constant NOP_INS = 32'h13;
  - typedef pipe_hs_t {valid, ready};
  - function clog2-safe LEVEL_W(DEPTH).
- One sub-module, pipe_buf_ram: a DEPTH x (DATA_W+1) register array with one write port and one asynchronous read port, reset to 0.
- Pointer, count and handshake logic stay in pipe_stage_buf.

Test Plan:
- DEPTH=2, push 0xA1 then 0xA2 with i_dn_ready=0:
  - o_level = 2, o_up_ready = 0.
  - After i_dn_ready=1, outputs are 0xA1 then 0xA2 in order, one per cycle.
- DEPTH=1, continuous i_up_valid=i_dn_ready=1 with data 1..8: output is 1..8 one cycle delayed, and o_up_ready stays 1 throughout.
- i_bubble=1 on a push of 0xDEAD: o_dn_data = BUBBLE_VAL (low word 0x13), o_dn_bubble = 1; the next normal push has o_dn_bubble = 0.
- DEPTH=4 full (4 entries), i_flush=1 with i_up_valid=1 in the same cycle: the next cycle has o_level = 0, o_dn_valid = 0, and the pushed data is absent.
- i_stall=1 for 3 cycles with 1 entry held and i_dn_ready=1: entry retained, o_up_ready = 0, o_level = 1; the entry pops on the first cycle after the stall releases.
- Assert i_rst_n=0 asynchronously between clock edges with 2 entries held: o_dn_valid falls to 0 immediately, without waiting for a clock edge.
